// File: rtl/axi_burst_read_engine_if.sv
// AXI4 read-address/read-data channels plus the AXI4-Stream output of the burst read engine.
// The master modport is the engine side; the slave modport is the memory/stream-sink side.
interface axi_burst_read_engine_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_burst_read_engine.sv
// AXI4 burst read master: issues cfg_burst_count INCR bursts from a latched base address, one
// outstanding at a time, and passes the returned beats straight through to an AXI4-Stream port.
module axi_burst_read_engine #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int ARID_VALUE = 0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_address,
  input  logic [31:0]             cfg_burst_count,
  input  logic [8:0]              cfg_burst_len,
  input  logic                    start,
  input  logic                    loop_enable,
  output logic                    busy,
  output logic                    rresp_error,
  axi_burst_read_engine_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  // Zero-length requests become single beats; anything above 256 saturates at the AXI4 maximum.
  function automatic logic [7:0] calc_arlen(input logic [8:0] len);
    logic [8:0] len_m1;
    len_m1 = len - 9'd1;
    if (len == 9'd0) begin
      calc_arlen = 8'd0;
    end else if (len > 9'd256) begin
      calc_arlen = 8'd255;
    end else begin
      calc_arlen = len_m1[7:0];
    end
  endfunction

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           count_r;
  logic [31:0]           burst_idx_r;
  logic [7:0]            arlen_r;
  logic                  rresp_error_r;

  logic                  start_accept_s;
  logic                  beat_s;
  logic                  burst_end_s;
  logic                  last_burst_s;
  logic [ADDR_WIDTH-1:0] step_s;
  logic                  unused_s;

  // Low address nibble is forced to zero and rid carries no meaning for a single-ID master.
  assign unused_s = ^{bus.m_axi_rid, cfg_base_address[3:0]};

  // Handshake qualifiers and the byte step from one burst to the next
  always_comb begin
    start_accept_s = (state_r == IDLE) && start && (cfg_burst_count != 32'd0);
    beat_s         = (state_r == DATA) && bus.m_axi_rvalid && bus.m_axis_tready;
    burst_end_s    = beat_s && bus.m_axi_rlast;
    last_burst_s   = ((burst_idx_r + 32'd1) == count_r);
    step_s         = ADDR_WIDTH'({({1'b0, arlen_r} + 9'd1), 4'b0000});
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_accept_s) begin
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (bus.m_axi_arready) begin
          state_s = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (burst_end_s) begin
          if (!last_burst_s || loop_enable) begin
            state_s = ADDR;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode: AR fields come from registers, the R-to-stream path is a direct pass-through
  always_comb begin
    bus.m_axi_araddr  = addr_r;
    bus.m_axi_arlen   = arlen_r;
    bus.m_axi_arsize  = 3'b100;
    bus.m_axi_arburst = 2'b01;
    bus.m_axi_arid    = ID_WIDTH'(ARID_VALUE);
    bus.m_axi_arvalid = (state_r == ADDR);
    bus.m_axi_rready  = 1'b0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tdata  = {DATA_WIDTH{1'b0}};
    busy              = (state_r != IDLE);
    rresp_error       = rresp_error_r;
    if (state_r == DATA) begin
      bus.m_axi_rready  = bus.m_axis_tready;
      bus.m_axis_tvalid = bus.m_axi_rvalid;
      bus.m_axis_tlast  = bus.m_axi_rvalid && bus.m_axi_rlast && last_burst_s;
      bus.m_axis_tdata  = bus.m_axi_rdata;
    end else begin
      bus.m_axi_rready  = 1'b0;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tlast  = 1'b0;
      bus.m_axis_tdata  = {DATA_WIDTH{1'b0}};
    end
  end

  // State register, latched configuration, burst walk and sticky error flag
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r       <= IDLE;
      base_r        <= {ADDR_WIDTH{1'b0}};
      addr_r        <= {ADDR_WIDTH{1'b0}};
      count_r       <= 32'd0;
      burst_idx_r   <= 32'd0;
      arlen_r       <= 8'd0;
      rresp_error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_accept_s) begin
        base_r      <= {cfg_base_address[ADDR_WIDTH-1:4], 4'b0000};
        addr_r      <= {cfg_base_address[ADDR_WIDTH-1:4], 4'b0000};
        count_r     <= cfg_burst_count;
        burst_idx_r <= 32'd0;
        arlen_r     <= calc_arlen(cfg_burst_len);
      end else if (burst_end_s) begin
        if (!last_burst_s) begin
          burst_idx_r <= burst_idx_r + 32'd1;
          addr_r      <= addr_r + step_s;
        end else if (loop_enable) begin
          burst_idx_r <= 32'd0;
          addr_r      <= base_r;
        end else begin
          burst_idx_r <= 32'd0;
          addr_r      <= addr_r;
        end
      end else begin
        burst_idx_r <= burst_idx_r;
        addr_r      <= addr_r;
      end
      if (beat_s && (bus.m_axi_rresp != 2'b00)) begin
        rresp_error_r <= 1'b1;
      end else begin
        rresp_error_r <= rresp_error_r;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_read_engine.sv
// Directed bench for axi_burst_read_engine: a table of passes checked against hand-computed
// addresses, lengths and beat counts, plus loop, error, zero-count and mid-burst reset sequences.
module tb_axi_burst_read_engine;
  localparam int AW = 48;
  localparam int DW = 128;
  localparam int IW = 4;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [31:0]   count;
    logic [8:0]    len;
    bit            bp;
    bit            retrig;
    logic [AW-1:0] exp_base;
    logic [7:0]    exp_arlen;
    logic [AW-1:0] exp_step;
    logic [AW-1:0] exp_addr1;
  } vec_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] cfg_base_address;
  logic [31:0]   cfg_burst_count;
  logic [8:0]    cfg_burst_len;
  logic          start;
  logic          loop_enable;
  logic          busy;
  logic          rresp_error;

  axi_burst_read_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_burst_read_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ARID_VALUE(0)) dut (
    .aclk             (aclk),
    .areset           (areset),
    .cfg_base_address (cfg_base_address),
    .cfg_burst_count  (cfg_burst_count),
    .cfg_burst_len    (cfg_burst_len),
    .start            (start),
    .loop_enable      (loop_enable),
    .busy             (busy),
    .rresp_error      (rresp_error),
    .bus              (bus)
  );

  always #5 aclk = ~aclk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            bp_mode = 1'b0;
  bit            err_armed = 1'b0;
  logic [DW-1:0] err_data = {DW{1'b0}};
  logic [DW-1:0] data_ctr = {DW{1'b0}};
  logic [DW-1:0] exp_data = {DW{1'b0}};

  bit            pend_valid = 1'b0;
  logic [7:0]    pend_len = 8'd0;
  int            beat_idx = 0;
  bit            in_data = 1'b0;
  bit            ar_hs = 1'b0;
  bit            r_hs = 1'b0;
  bit            r_last_smp = 1'b0;
  logic [7:0]    hs_len = 8'd0;
  bit            areset_smp = 1'b0;
  bit            areset_prev = 1'b0;
  bit            prev_ar_wait = 1'b0;
  logic [AW-1:0] prev_araddr = {AW{1'b0}};
  logic [7:0]    prev_arlen = 8'd0;

  logic [AW-1:0] ar_addr_q[$];
  logic [7:0]    ar_len_q[$];
  int            tlast_q[$];
  int            n_beats = 0;
  int            last_tlast_cyc = -10;

  vec_t          vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_log();
    ar_addr_q.delete();
    ar_len_q.delete();
    tlast_q.delete();
    n_beats        = 0;
    last_tlast_cyc = -10;
    exp_data       = data_ctr;
  endtask

  // Memory slave and stream sink: drive at negedge, sample 2 time units later
  initial begin : slave
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = {DW{1'b0}};
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rid     = 4'h5;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      cyc++;
      if (r_hs) begin
        data_ctr = data_ctr + 1'b1;
        beat_idx++;
        if (r_last_smp) begin
          pend_valid = 1'b0;
          in_data    = 1'b0;
        end
      end
      if (ar_hs) begin
        pend_valid = 1'b1;
        pend_len   = hs_len;
        beat_idx   = 0;
        in_data    = 1'b1;
      end
      if (areset_smp) begin
        pend_valid = 1'b0;
        in_data    = 1'b0;
        beat_idx   = 0;
      end
      if (!pend_valid) begin
        bus.m_axi_rvalid = 1'b0;
      end else if (!(bus.m_axi_rvalid && !r_hs)) begin
        bus.m_axi_rvalid = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      bus.m_axi_rdata   = data_ctr;
      bus.m_axi_rlast   = pend_valid && (beat_idx == int'(pend_len));
      bus.m_axi_rresp   = (err_armed && (data_ctr == err_data)) ? 2'b10 : 2'b00;
      bus.m_axi_arready = bp_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      bus.m_axis_tready = bp_mode ? ~bus.m_axis_tready : 1'b1;
      #2;
      areset_prev = areset_smp;
      areset_smp  = areset;
      if (prev_ar_wait && !areset_prev) begin
        check("arvalid_hold", bus.m_axi_arvalid, 1'b1);
        check("araddr_hold", bus.m_axi_araddr, prev_araddr);
        check("arlen_hold", bus.m_axi_arlen, prev_arlen);
      end
      prev_ar_wait = bus.m_axi_arvalid && !bus.m_axi_arready;
      prev_araddr  = bus.m_axi_araddr;
      prev_arlen   = bus.m_axi_arlen;
      ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
      if (ar_hs) begin
        ar_addr_q.push_back(bus.m_axi_araddr);
        ar_len_q.push_back(bus.m_axi_arlen);
        hs_len = bus.m_axi_arlen;
      end
      check("rready", bus.m_axi_rready, in_data && bus.m_axis_tready);
      check("tvalid", bus.m_axis_tvalid, in_data && bus.m_axi_rvalid);
      r_hs       = bus.m_axi_rvalid && bus.m_axi_rready;
      r_last_smp = bus.m_axi_rlast;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        n_beats++;
        check("tdata", bus.m_axis_tdata, exp_data);
        exp_data = exp_data + 1'b1;
        if (bus.m_axis_tlast) begin
          tlast_q.push_back(n_beats);
          last_tlast_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_idle(output int fall);
    int n;
    n    = 0;
    fall = -1;
    while (n < 6000) begin
      @(negedge aclk);
      #3;
      if (!busy) begin
        fall = cyc;
        break;
      end
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int            fall;
    int            exp_beats;
    logic [AW-1:0] a;
    @(negedge aclk);
    bp_mode = v.bp;
    clear_log();
    cfg_base_address = v.base;
    cfg_burst_count  = v.count;
    cfg_burst_len    = v.len;
    loop_enable      = 1'b0;
    start            = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    #3;
    check({tag, "_start_arvalid"}, bus.m_axi_arvalid, 1'b1);
    check({tag, "_start_busy"}, busy, 1'b1);
    if (v.retrig) begin
      @(negedge aclk);
      cfg_base_address = 48'h0000_DEAD_0000;
      cfg_burst_count  = 32'd7;
      cfg_burst_len    = 9'd3;
      start            = 1'b1;
      @(negedge aclk);
      start = 1'b0;
    end
    wait_idle(fall);
    exp_beats = int'(v.count) * (int'(v.exp_arlen) + 1);
    check({tag, "_ar_count"}, ar_addr_q.size(), v.count);
    a = v.exp_base;
    foreach (ar_addr_q[k]) begin
      check({tag, "_araddr"}, ar_addr_q[k], a);
      check({tag, "_arlen"}, ar_len_q[k], v.exp_arlen);
      a = a + v.exp_step;
    end
    if (v.count > 32'd1) check({tag, "_araddr_second"}, ar_addr_q[1], v.exp_addr1);
    check({tag, "_beats"}, n_beats, exp_beats);
    check({tag, "_tlast_count"}, tlast_q.size(), 1);
    if (tlast_q.size() > 0) check({tag, "_tlast_pos"}, tlast_q[0], exp_beats);
    check({tag, "_busy_drop"}, fall, last_tlast_cyc + 1);
  endtask

  initial begin : main
    int            fall;
    int            n;
    logic [AW-1:0] loop_exp[6];
    areset           = 1'b1;
    cfg_base_address = {AW{1'b0}};
    cfg_burst_count  = 32'd0;
    cfg_burst_len    = 9'd0;
    start            = 1'b0;
    loop_enable      = 1'b0;

    vecs[0] = '{48'h0000_2000_0000, 32'd2, 9'd16,  1'b0, 1'b0, 48'h0000_2000_0000, 8'd15,  48'h100,  48'h0000_2000_0100};
    vecs[1] = '{48'h0000_0000_1000, 32'd3, 9'd0,   1'b1, 1'b0, 48'h0000_0000_1000, 8'd0,   48'h10,   48'h0000_0000_1010};
    vecs[2] = '{48'h0000_4000_0000, 32'd2, 9'd300, 1'b0, 1'b0, 48'h0000_4000_0000, 8'd255, 48'h1000, 48'h0000_4000_1000};
    vecs[3] = '{48'h0000_0000_5008, 32'd1, 9'd256, 1'b1, 1'b1, 48'h0000_0000_5000, 8'd255, 48'h1000, 48'h0000_0000_0000};
    vecs[4] = '{48'hFFFF_FFFF_FFC0, 32'd2, 9'd4,   1'b1, 1'b0, 48'hFFFF_FFFF_FFC0, 8'd3,   48'h40,   48'h0000_0000_0000};
    vecs[5] = '{48'h0000_0000_0300, 32'd4, 9'd1,   1'b1, 1'b1, 48'h0000_0000_0300, 8'd0,   48'h10,   48'h0000_0000_0310};
    vecs[6] = '{48'h0000_0000_9000, 32'd2, 9'd4,   1'b0, 1'b1, 48'h0000_0000_9000, 8'd3,   48'h40,   48'h0000_0000_9040};
    vecs[7] = '{48'h0000_0000_C000, 32'd1, 9'd2,   1'b1, 1'b0, 48'h0000_0000_C000, 8'd1,   48'h20,   48'h0000_0000_0000};
    vecs[8] = '{48'h0000_0000_B000, 32'd2, 9'd8,   1'b1, 1'b0, 48'h0000_0000_B000, 8'd7,   48'h80,   48'h0000_0000_B080};

    repeat (3) @(negedge aclk);
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_rresp_error", rresp_error, 1'b0);
    check("rst_arvalid", bus.m_axi_arvalid, 1'b0);
    check("rst_araddr", bus.m_axi_araddr, 48'h0);
    check("rst_arlen", bus.m_axi_arlen, 8'd0);
    check("rst_arsize", bus.m_axi_arsize, 3'b100);
    check("rst_arburst", bus.m_axi_arburst, 2'b01);
    check("rst_arid", bus.m_axi_arid, 4'd0);
    check("rst_tlast", bus.m_axis_tlast, 1'b0);
    check("rst_tdata", bus.m_axis_tdata, 128'h0);
    @(negedge aclk);
    areset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Zero burst count must be ignored
    @(negedge aclk);
    bp_mode = 1'b0;
    clear_log();
    cfg_base_address = 48'h0000_0000_7000;
    cfg_burst_count  = 32'd0;
    cfg_burst_len    = 9'd8;
    start            = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (4) begin
      #3;
      check("cnt0_busy", busy, 1'b0);
      check("cnt0_arvalid", bus.m_axi_arvalid, 1'b0);
      @(negedge aclk);
    end
    check("cnt0_ar_count", ar_addr_q.size(), 0);

    // Loop mode: loop_enable dropped during the second pass
    clear_log();
    cfg_base_address = 48'h0000_0000_8000;
    cfg_burst_count  = 32'd3;
    cfg_burst_len    = 9'd4;
    loop_enable      = 1'b1;
    start            = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    n     = 0;
    fall  = -1;
    while (n < 2000) begin
      @(negedge aclk);
      if (n_beats >= 14) loop_enable = 1'b0;
      #3;
      if (!busy) begin
        fall = cyc;
        break;
      end
      n++;
    end
    check("loop_idle", busy, 1'b0);
    check("loop_beats", n_beats, 24);
    check("loop_ar_count", ar_addr_q.size(), 6);
    loop_exp[0] = 48'h0000_0000_8000;
    loop_exp[1] = 48'h0000_0000_8040;
    loop_exp[2] = 48'h0000_0000_8080;
    loop_exp[3] = 48'h0000_0000_8000;
    loop_exp[4] = 48'h0000_0000_8040;
    loop_exp[5] = 48'h0000_0000_8080;
    foreach (ar_addr_q[k]) begin
      if (k < 6) check("loop_araddr", ar_addr_q[k], loop_exp[k]);
    end
    check("loop_tlast_count", tlast_q.size(), 2);
    if (tlast_q.size() > 1) begin
      check("loop_tlast_first", tlast_q[0], 12);
      check("loop_tlast_second", tlast_q[1], 24);
    end
    check("loop_busy_drop", fall, last_tlast_cyc + 1);

    // SLVERR on the third beat; flag is sticky across a later clean pass
    #3;
    check("err_before", rresp_error, 1'b0);
    err_data  = data_ctr + 2'd2;
    err_armed = 1'b1;
    run_vec("err", vecs[6]);
    check("err_set", rresp_error, 1'b1);
    err_armed = 1'b0;
    run_vec("err_clean", vecs[7]);
    check("err_sticky", rresp_error, 1'b1);

    // Reset in the middle of a data phase
    @(negedge aclk);
    bp_mode = 1'b0;
    clear_log();
    cfg_base_address = 48'h0000_0000_A000;
    cfg_burst_count  = 32'd2;
    cfg_burst_len    = 9'd16;
    start            = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    n     = 0;
    while ((n_beats < 5) && (n < 200)) begin
      @(negedge aclk);
      #3;
      n++;
    end
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #3;
    check("midrst_arvalid", bus.m_axi_arvalid, 1'b0);
    check("midrst_rready", bus.m_axi_rready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rresp_error", rresp_error, 1'b0);
    check("midrst_tvalid", bus.m_axis_tvalid, 1'b0);
    run_vec("after_rst", vecs[8]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
